// File: rtl/io_responder.sv
// Device-side responder for the four-lane processor I/O handshake: output words are
// caught and handed to peripheral sinks, and buffered peripheral words are offered to the processor.
module io_lane #(
  parameter int LANE_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enter_out,
  input  logic [LANE_W-1:0] dout,
  input  logic              sink_ack,
  output logic [LANE_W-1:0] sink_data,
  output logic              sink_valid,
  output logic              done_out,
  input  logic              src_valid,
  input  logic [LANE_W-1:0] src_data,
  input  logic              consume,
  output logic [LANE_W-1:0] din,
  output logic              src_ack,
  output logic              full
);
  // Each busy state owns exactly one bit, so the handshake outputs come straight off flops.
  typedef enum logic [1:0] {O_IDLE = 2'b00, O_SINK = 2'b01, O_DONE = 2'b10} o_state_t;
  typedef enum logic {I_EMPTY = 1'b0, I_FULL = 1'b1} i_state_t;

  o_state_t o_q, o_d;
  i_state_t i_q, i_d;
  logic     capture;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_q <= O_IDLE;
    else        o_q <= o_d;

  always_comb begin
    o_d = o_q;
    case (o_q)
      O_IDLE:  if (enter_out)  o_d = O_SINK;
      O_SINK:  if (sink_ack)   o_d = O_DONE;
      O_DONE:  if (!enter_out) o_d = O_IDLE;
      default: o_d = O_IDLE;
    endcase
  end

  assign sink_valid = o_q[0];
  assign done_out   = o_q[1];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                          sink_data <= '0;
    else if (o_q == O_IDLE && enter_out) sink_data <= dout;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) i_q <= I_EMPTY;
    else        i_q <= i_d;

  always_comb begin
    i_d     = i_q;
    capture = 1'b0;
    case (i_q)
      I_EMPTY: if (src_valid) begin
        capture = 1'b1;
        i_d     = I_FULL;
      end
      I_FULL:  if (consume) i_d = I_EMPTY;
      default: i_d = I_EMPTY;
    endcase
  end

  assign full = (i_q == I_FULL);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      din     <= '0;
      src_ack <= 1'b0;
    end else begin
      src_ack <= capture;
      if (capture) din <= src_data;
    end
endmodule

module io_responder #(
  parameter int LANE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*LANE_W-1:0] dev_out,
  input  logic [3:0]          enter_out,
  output logic [3:0]          done_out,
  input  logic                in_ready,
  output logic [4*LANE_W-1:0] dev_in,
  output logic [3:0]          enter_in,
  output logic [4*LANE_W-1:0] sink_data,
  output logic [3:0]          sink_valid,
  input  logic [3:0]          sink_ack,
  input  logic [4*LANE_W-1:0] src_data,
  input  logic [3:0]          src_valid,
  output logic [3:0]          src_ack
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] full, consume, pick;

  // A granted word is consumed when the processor drops in_ready.
  assign consume = {NUM_LANES{~in_ready}} & enter_in;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    io_lane #(.LANE_W(LANE_W)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .enter_out  (enter_out[i]),
      .dout       (dev_out[i*LANE_W +: LANE_W]),
      .sink_ack   (sink_ack[i]),
      .sink_data  (sink_data[i*LANE_W +: LANE_W]),
      .sink_valid (sink_valid[i]),
      .done_out   (done_out[i]),
      .src_valid  (src_valid[i]),
      .src_data   (src_data[i*LANE_W +: LANE_W]),
      .consume    (consume[i]),
      .din        (dev_in[i*LANE_W +: LANE_W]),
      .src_ack    (src_ack[i]),
      .full       (full[i])
    );
  end

  always_comb begin
    pick = '0;
    for (int i = NUM_LANES-1; i >= 0; i--)
      if (full[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
  end

  // Grant is taken once per in_ready window and frozen until in_ready falls.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)               enter_in <= '0;
    else if (!in_ready)       enter_in <= '0;
    else if (enter_in == '0)  enter_in <= pick;
endmodule
